// File: rtl/inv_trans_cr.sv
// Inverse skin-tone chroma transform: rebuilds Cr from transformed Cr' and luma Y
// through a 4-stage valid pipeline. Define INV_TRANS_CR_ROUND_EN for round-half-up output.
module inv_trans_cr (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y,
    input  logic [7:0] cr_t,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] cr,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [7:0]  K_L     = 8'd125;
    localparam logic [7:0]  K_H     = 8'd188;
    localparam logic [7:0]  Y_MIN   = 8'd16;
    localparam logic [7:0]  Y_MAX   = 8'd235;
    localparam logic [31:0] RECIP_L = 32'd601;
    localparam logic [31:0] RECIP_H = 32'd1394;
    localparam logic [31:0] SLOPE_WL = 32'd4803;
    localparam logic [31:0] SLOPE_CL = 32'd2560;
    localparam logic [31:0] SLOPE_WH = 32'd7363;
    localparam logic [31:0] SLOPE_CH = 32'd5632;
    localparam logic [31:0] W_CR    = 32'd9923;
    localparam logic [31:0] WL      = 32'd5120;
    localparam logic [31:0] WH      = 32'd2560;
    localparam logic [31:0] C0      = 32'd39424;
    localparam logic signed [35:0] INV_WCR = 36'sd1691;

    typedef enum logic [1:0] {
        REG_MID  = 2'd0,
        REG_LOW  = 2'd1,
        REG_HIGH = 2'd2
    } region_t;

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage 1: clamp luma, classify region, centre Cr'
    logic [7:0]        yc_d, yc_q;
    region_t           region_d, region_q;
    logic signed [8:0] d1_d, d1_q;
    logic              v1_q;

    always_comb begin
        yc_d = y;
        if (y < Y_MIN)
            yc_d = Y_MIN;
        else if (y > Y_MAX)
            yc_d = Y_MAX;
        region_d = REG_MID;
        if (yc_d < K_L)
            region_d = REG_LOW;
        else if (yc_d > K_H)
            region_d = REG_HIGH;
        d1_d = $signed({1'b0, cr_t}) - 9'sd154;
    end

    // Stage 2: cluster width and centre from constant reciprocals
    logic [7:0]        low_span, low_gap, high_span, high_gap;
    logic [31:0]       w_low_prod, c_low_prod, w_high_prod, c_high_prod;
    logic [15:0]       w2_d, w2_q, center2_d, center2_q;
    logic signed [8:0] d2_q;
    logic              v2_q;

    assign low_span    = yc_q - Y_MIN;
    assign low_gap     = K_L - yc_q;
    assign high_span   = Y_MAX - yc_q;
    assign high_gap    = yc_q - K_H;
    assign w_low_prod  = {24'd0, low_span}  * SLOPE_WL * RECIP_L;
    assign c_low_prod  = {24'd0, low_gap}   * SLOPE_CL * RECIP_L;
    assign w_high_prod = {24'd0, high_span} * SLOPE_WH * RECIP_H;
    assign c_high_prod = {24'd0, high_gap}  * SLOPE_CH * RECIP_H;

    always_comb begin
        w2_d      = W_CR[15:0];
        center2_d = C0[15:0];
        case (region_q)
            REG_LOW: begin
                w2_d      = 16'(WL + (w_low_prod >> 16));
                center2_d = 16'(C0 - (c_low_prod >> 16));
            end
            REG_HIGH: begin
                w2_d      = 16'(WH + (w_high_prod >> 16));
                center2_d = 16'(C0 + (c_high_prod >> 16));
            end
            default: begin
                w2_d      = W_CR[15:0];
                center2_d = C0[15:0];
            end
        endcase
    end

    // Stage 3: rescale the offset; taking the top bits is a floor shift
    logic signed [35:0] d_ext, w_ext, prod3;
    logic signed [19:0] p3_q;
    logic [15:0]        center3_q;
    logic               v3_q;

    assign d_ext = {{27{d2_q[8]}}, d2_q};
    assign w_ext = {20'd0, w2_q};
    assign prod3 = d_ext * w_ext * INV_WCR;

    // Stage 4: recentre, optional rounding, saturate to 8 bits
    logic signed [20:0] s4, r4;
    logic [7:0]         cr_d, cr_q;
    logic               v4_q;

    assign s4 = {p3_q[19], p3_q} + {5'd0, center3_q};
`ifdef INV_TRANS_CR_ROUND_EN
    assign r4 = s4 + 21'sd128;
`else
    assign r4 = s4;
`endif

    always_comb begin
        cr_d = r4[15:8];
        if (r4[20])
            cr_d = 8'd0;
        else if (r4[19:16] != 4'd0)
            cr_d = 8'd255;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            yc_q      <= 8'd0;
            region_q  <= REG_MID;
            d1_q      <= 9'sd0;
            d2_q      <= 9'sd0;
            w2_q      <= 16'd0;
            center2_q <= 16'd0;
            p3_q      <= 20'sd0;
            center3_q <= 16'd0;
            cr_q      <= 8'd0;
        end else if (en) begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            v4_q      <= v3_q;
            yc_q      <= yc_d;
            region_q  <= region_d;
            d1_q      <= d1_d;
            d2_q      <= d1_q;
            w2_q      <= w2_d;
            center2_q <= center2_d;
            p3_q      <= prod3[35:16];
            center3_q <= center2_q;
            cr_q      <= cr_d;
        end
    end

    assign cr        = cr_q;
    assign out_valid = v4_q;

endmodule
